// File: rtl/tick_timer_pkg.sv
// Shared types and default widths for the tick interval timer.
package tick_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_OVR_W = 4;

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter for tick intervals; raises expire when a tick lands on a count of one.
module tick_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_reload,
    input  logic [CNT_W-1:0] i_reload_val,
    output logic [CNT_W-1:0] o_count,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_one;

    assign w_at_one = (r_count == CNT_W'(1));
    assign o_expire = i_en && w_at_one;
    assign o_count  = r_count;

    // A count of zero never decrements, so the counter cannot wrap without an expiry.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            if (w_at_one) begin
                r_count <= i_reload ? i_reload_val : '0;
            end else if (r_count != '0) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tick_interval_timer.sv
// Programmable one-shot/periodic tick interval timer with sticky irq and overrun flags.
// Optional overrun event counter built only when TIT_OVR_CNT_EN is defined.
module tick_interval_timer
    import tick_timer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int OVR_W = DEF_OVR_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tick_in,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_periodic,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_irq_ack,
    output logic             o_irq,
    output logic             o_overrun,
    output logic             o_busy,
    output logic             o_start_err,
    output logic [CNT_W-1:0] o_count_out,
    output logic [OVR_W-1:0] o_ovr_cnt
);

    state_t           r_state;
    logic             r_irq;
    logic             r_overrun;
    logic             r_busy;
    logic             r_start_err;
    logic             r_mode;
    logic [CNT_W-1:0] r_reload;

    logic             w_load_zero;
    logic             w_start_ok;
    logic             w_start_bad;
    logic             w_cnt_en;
    logic             w_expire;
    logic             w_ovr_event;

    // Stop outranks start, so a simultaneous start is neither taken nor flagged.
    assign w_load_zero = (i_load_val == '0);
    assign w_start_ok  = i_start && !i_stop && !w_load_zero;
    assign w_start_bad = i_start && !i_stop && w_load_zero;
    assign w_cnt_en    = i_tick_in && (r_state == RUN) && !w_start_ok && !i_stop;
    assign w_ovr_event = w_expire && r_irq && !i_irq_ack;

    tick_down_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (i_stop),
        .i_load       (w_start_ok),
        .i_load_val   (i_load_val),
        .i_en         (w_cnt_en),
        .i_reload     (r_mode),
        .i_reload_val (r_reload),
        .o_count      (o_count_out),
        .o_expire     (w_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_irq       <= 1'b0;
            r_overrun   <= 1'b0;
            r_start_err <= 1'b0;
            r_mode      <= 1'b0;
            r_reload    <= '0;
        end else begin
            r_start_err <= w_start_bad;

            if (i_stop) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else if (w_start_ok) begin
                r_state  <= RUN;
                r_busy   <= 1'b1;
                r_reload <= i_load_val;
                r_mode   <= i_periodic;
            end else begin
                case (r_state)
                    RUN: begin
                        if (w_expire && !r_mode) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                        end
                    end
                    DONE: begin
                        if (i_irq_ack) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end

            // An expiry in the acknowledge cycle wins, leaving irq set for the new event.
            if (w_expire) begin
                r_irq <= 1'b1;
            end else if (i_irq_ack) begin
                r_irq <= 1'b0;
            end

            if (i_irq_ack) begin
                r_overrun <= 1'b0;
            end else if (w_ovr_event) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef TIT_OVR_CNT_EN
    logic [OVR_W-1:0] r_ovr_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_irq_ack) begin
            r_ovr_cnt <= '0;
        end else if (w_ovr_event && (r_ovr_cnt != {OVR_W{1'b1}})) begin
            r_ovr_cnt <= r_ovr_cnt + OVR_W'(1);
        end
    end

    assign o_ovr_cnt = r_ovr_cnt;
`else
    assign o_ovr_cnt = '0;
`endif

    assign o_irq       = r_irq;
    assign o_overrun   = r_overrun;
    assign o_busy      = r_busy;
    assign o_start_err = r_start_err;

endmodule

// File: tb/tb_tick_interval_timer.sv
// Table-driven self-checking bench for tick_interval_timer; honours TIT_OVR_CNT_EN for ovr_cnt expectations.
module tb_tick_interval_timer;

    localparam int CNT_W = 8;
    localparam int OVR_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tickIn = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             periodic = 1'b0;
    logic [CNT_W-1:0] loadVal = '0;
    logic             irqAck = 1'b0;
    logic             irq;
    logic             overrun;
    logic             busy;
    logic             startErr;
    logic [CNT_W-1:0] countOut;
    logic [OVR_W-1:0] ovrCnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       tick;
        logic       st;
        logic       sp;
        logic       per;
        logic [7:0] lv;
        logic       ack;
        logic       eIrq;
        logic       eOvr;
        logic       eBusy;
        logic       eErr;
        logic [7:0] eCnt;
        logic [3:0] eOvc;
    } vec_t;

    vec_t vecs[$];

    tick_interval_timer #(
        .CNT_W(CNT_W),
        .OVR_W(OVR_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_tick_in   (tickIn),
        .i_start     (start),
        .i_stop      (stop),
        .i_periodic  (periodic),
        .i_load_val  (loadVal),
        .i_irq_ack   (irqAck),
        .o_irq       (irq),
        .o_overrun   (overrun),
        .o_busy      (busy),
        .o_start_err (startErr),
        .o_count_out (countOut),
        .o_ovr_cnt   (ovrCnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ovcExp(input logic [3:0] v);
`ifdef TIT_OVR_CNT_EN
        return v;
`else
        return 4'd0;
`endif
    endfunction

    function automatic vec_t mk(input logic t, input logic s, input logic p, input logic pr,
                                input logic [7:0] l, input logic a, input logic ei,
                                input logic eo, input logic eb, input logic ee,
                                input logic [7:0] ec, input logic [3:0] ov);
        vec_t v;
        v.tick = t; v.st = s; v.sp = p; v.per = pr; v.lv = l; v.ack = a;
        v.eIrq = ei; v.eOvr = eo; v.eBusy = eb; v.eErr = ee; v.eCnt = ec; v.eOvc = ovcExp(ov);
        return v;
    endfunction

    // Drive one cycle of inputs, then leave them idle after the edge.
    task automatic applyStimulus(input logic t, input logic s, input logic p, input logic pr,
                                 input logic [7:0] l, input logic a);
        tickIn = t; start = s; stop = p; periodic = pr; loadVal = l; irqAck = a;
        @(posedge clk);
        #1;
        tickIn = 1'b0; start = 1'b0; stop = 1'b0; irqAck = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic ei, input logic eo,
                               input logic eb, input logic ee, input logic [7:0] ec,
                               input logic [3:0] ov);
        checks++;
        if (irq !== ei || overrun !== eo || busy !== eb || startErr !== ee ||
            countOut !== ec || ovrCnt !== ov) begin
            failures++;
            $display("[TB] FAIL %s: got irq=%b ovr=%b busy=%b err=%b cnt=%0d ovc=%0d, want irq=%b ovr=%b busy=%b err=%b cnt=%0d ovc=%0d",
                     name, irq, overrun, busy, startErr, countOut, ovrCnt,
                     ei, eo, eb, ee, ec, ov);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // One-shot interval of 3 ticks, then acknowledge
        vecs.push_back(mk(0,1,0,0,8'd3,0, 0,0,1,0,8'd3,0));
        vecs.push_back(mk(1,0,0,0,8'd0,0, 0,0,1,0,8'd2,0));
        vecs.push_back(mk(1,0,0,0,8'd0,0, 0,0,1,0,8'd1,0));
        vecs.push_back(mk(1,0,0,0,8'd0,0, 1,0,0,0,8'd0,0));
        vecs.push_back(mk(0,0,0,0,8'd0,0, 1,0,0,0,8'd0,0));
        vecs.push_back(mk(0,0,0,0,8'd0,1, 0,0,0,0,8'd0,0));
        // Periodic interval of 2 ticks, acked after every expiry
        vecs.push_back(mk(0,1,0,1,8'd2,0, 0,0,1,0,8'd2,0));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(1,0,0,0,8'd0,0, 0,0,1,0,8'd1,0));
            vecs.push_back(mk(1,0,0,0,8'd0,0, 1,0,1,0,8'd2,0));
            vecs.push_back(mk(0,0,0,0,8'd0,1, 0,0,1,0,8'd2,0));
        end
        // Overrun with a 1-tick period
        vecs.push_back(mk(0,1,0,1,8'd1,0, 0,0,1,0,8'd1,0));
        vecs.push_back(mk(1,0,0,0,8'd0,0, 1,0,1,0,8'd1,0));
        vecs.push_back(mk(1,0,0,0,8'd0,0, 1,1,1,0,8'd1,1));
        vecs.push_back(mk(1,0,0,0,8'd0,0, 1,1,1,0,8'd1,2));
        vecs.push_back(mk(0,0,0,0,8'd0,1, 0,0,1,0,8'd1,0));
        // Ack colliding with expiry
        vecs.push_back(mk(1,0,0,0,8'd0,0, 1,0,1,0,8'd1,0));
        vecs.push_back(mk(1,0,0,0,8'd0,1, 1,0,1,0,8'd1,0));
        vecs.push_back(mk(0,0,0,0,8'd0,1, 0,0,1,0,8'd1,0));
        vecs.push_back(mk(0,0,1,0,8'd0,0, 0,0,0,0,8'd0,0));
        // Control corners: zero load, stop+start, retrigger at count 1, idle tick
        vecs.push_back(mk(0,1,0,0,8'd0,0, 0,0,0,1,8'd0,0));
        vecs.push_back(mk(0,0,0,0,8'd0,0, 0,0,0,0,8'd0,0));
        vecs.push_back(mk(0,1,0,0,8'd4,0, 0,0,1,0,8'd4,0));
        vecs.push_back(mk(1,1,0,0,8'd0,0, 0,0,1,1,8'd3,0));
        vecs.push_back(mk(0,1,1,0,8'd7,0, 0,0,0,0,8'd0,0));
        vecs.push_back(mk(0,1,0,0,8'd2,0, 0,0,1,0,8'd2,0));
        vecs.push_back(mk(1,0,0,0,8'd0,0, 0,0,1,0,8'd1,0));
        vecs.push_back(mk(1,1,0,0,8'd5,0, 0,0,1,0,8'd5,0));
        vecs.push_back(mk(1,0,0,0,8'd0,0, 0,0,1,0,8'd4,0));
        vecs.push_back(mk(0,0,1,0,8'd0,0, 0,0,0,0,8'd0,0));
        vecs.push_back(mk(1,0,0,0,8'd0,0, 0,0,0,0,8'd0,0));

        doReset();
        checkOutput("reset", 0, 0, 0, 0, 8'd0, 4'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].tick, vecs[i].st, vecs[i].sp, vecs[i].per, vecs[i].lv, vecs[i].ack);
            checkOutput($sformatf("vec%0d", i), vecs[i].eIrq, vecs[i].eOvr, vecs[i].eBusy,
                        vecs[i].eErr, vecs[i].eCnt, vecs[i].eOvc);
        end

        // Restart straight from DONE while irq is still pending
        applyStimulus(0, 1, 0, 0, 8'd2, 0);
        applyStimulus(1, 0, 0, 0, 8'd0, 0);
        applyStimulus(1, 0, 0, 0, 8'd0, 0);
        checkOutput("done_reached", 1, 0, 0, 0, 8'd0, 4'd0);
        applyStimulus(0, 1, 0, 0, 8'd3, 0);
        checkOutput("done_restart", 1, 0, 1, 0, 8'd3, 4'd0);
        applyStimulus(0, 0, 1, 0, 8'd0, 1);
        checkOutput("stop_with_ack", 0, 0, 0, 0, 8'd0, 4'd0);

        // Overrun counter saturation: 1 expiry plus 19 overruns
        applyStimulus(0, 1, 0, 1, 8'd1, 0);
        for (int k = 0; k < 20; k++) applyStimulus(1, 0, 0, 0, 8'd0, 0);
        checkOutput("ovr_saturate", 1, 1, 1, 0, 8'd1, ovcExp(4'd15));
        applyStimulus(0, 0, 0, 0, 8'd0, 1);
        checkOutput("ovr_ack", 0, 0, 1, 0, 8'd1, 4'd0);

        // Reset mid-interval drops the pending irq
        applyStimulus(1, 0, 0, 0, 8'd0, 0);
        applyStimulus(1, 0, 0, 0, 8'd0, 0);
        checkOutput("pre_reset", 1, 1, 1, 0, 8'd1, ovcExp(4'd1));
        doReset();
        checkOutput("mid_reset", 0, 0, 0, 0, 8'd0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
